// File: rtl/use_stream_collector.sv
// use_stream_collector
//
// Collects variable-length elements from NUM_ELEMENTS parallel upstream
// slots and serializes them, strictly in element-ID order, onto an
// AXI4-Stream style master interface of DATA_BUS_WIDTH_BYTES per beat.
//
// Ports
//   clk                    rising-edge clock for all logic
//   reset                  synchronous, active-high reset
//   USEStreamIn            element data; slot i occupies MAX_USE_BYTES bytes, byte 0 lowest
//   USEStreamByteLengthIn  byte length per slot, LENGTH_WIDTH bits each
//   USEStreamReadyIn       per-slot single-cycle capture pulse
//   m_axis_tdata/tkeep     output beat and byte-valid mask (unused bytes are zero)
//   m_axis_tvalid/tready   beat handshake
//   m_axis_tlast           last beat of an element
//   overflow_error         sticky: capture attempted into an occupied slot
//   length_error           sticky: capture with length 0 or above MAX_USE_BYTES
//   element_count          number of elements fully emitted (wraps at 16 bits)
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for slot next_id to fill; no beat presented
// SEND   | serializer owns an element; beats presented on m_axis_*
module use_stream_collector #(
    parameter int NUM_ELEMENTS         = 6,
    parameter int DATA_BUS_WIDTH_BYTES = 8,
    parameter int MAX_USE_BYTES        = 38,
    parameter int LENGTH_WIDTH         = 6
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_ELEMENTS*MAX_USE_BYTES*8-1:0] USEStreamIn,
    input  logic [NUM_ELEMENTS*LENGTH_WIDTH-1:0]    USEStreamByteLengthIn,
    input  logic [NUM_ELEMENTS-1:0]                 USEStreamReadyIn,
    output logic [DATA_BUS_WIDTH_BYTES*8-1:0]       m_axis_tdata,
    output logic [DATA_BUS_WIDTH_BYTES-1:0]         m_axis_tkeep,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic                                    m_axis_tlast,
    output logic                                    overflow_error,
    output logic                                    length_error,
    output logic [15:0]                             element_count
);

    localparam int ID_W     = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam int SLOT_W   = MAX_USE_BYTES * 8;
    localparam int DBW      = DATA_BUS_WIDTH_BYTES * 8;
    // One spare beat of zero padding so the low beat is always defined,
    // even when MAX_USE_BYTES is smaller than the bus.
    localparam int SER_W    = SLOT_W + DBW;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [ID_W-1:0]           next_id_q;
    logic [NUM_ELEMENTS-1:0]   slot_full_q;
    logic [SLOT_W-1:0]         slot_data_q [NUM_ELEMENTS];
    logic [LENGTH_WIDTH-1:0]   slot_len_q  [NUM_ELEMENTS];
    logic [SER_W-1:0]          ser_q;
    logic [LENGTH_WIDTH-1:0]   rem_q;
    logic [15:0]               count_q;
    logic                      ovf_q;
    logic                      len_err_q;

    logic                      release_w;
    logic                      beat_last_w;
    logic                      fire_w;
    logic [NUM_ELEMENTS-1:0]   cap_bad_w;
    logic [NUM_ELEMENTS-1:0]   rel_slot_w;
    logic [SLOT_W-1:0]         cap_data_w [NUM_ELEMENTS];
    logic [LENGTH_WIDTH-1:0]   cap_len_w  [NUM_ELEMENTS];

    for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_slot
        assign cap_data_w[g] = USEStreamIn[g*SLOT_W +: SLOT_W];
        assign cap_len_w[g]  = USEStreamByteLengthIn[g*LENGTH_WIDTH +: LENGTH_WIDTH];
        assign cap_bad_w[g]  = (cap_len_w[g] == '0) || (int'(cap_len_w[g]) > MAX_USE_BYTES);
        assign rel_slot_w[g] = release_w && (next_id_q == ID_W'(g));
    end

    // rem_q counts bytes not yet handshaken for the element in flight.
    assign beat_last_w = (int'(rem_q) <= DATA_BUS_WIDTH_BYTES);
    assign fire_w      = m_axis_tvalid && m_axis_tready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        release_w = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (slot_full_q[next_id_q]) begin
                    state_d   = S_SEND;
                    release_w = 1'b1;
                end
            end
            S_SEND: begin
                if (m_axis_tready && beat_last_w) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: the current beat is always the low bus-width of ser_q,
    // with bytes past the element length masked to zero.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tdata  = '0;
        if (state_q == S_SEND) begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = beat_last_w;
            for (int k = 0; k < DATA_BUS_WIDTH_BYTES; k++) begin
                if (int'(rem_q) > k) begin
                    m_axis_tkeep[k]        = 1'b1;
                    m_axis_tdata[k*8 +: 8] = ser_q[k*8 +: 8];
                end
            end
        end
    end

    // Capture slots, serializer, pointer and status
    always_ff @(posedge clk) begin
        if (reset) begin
            next_id_q   <= '0;
            slot_full_q <= '0;
            ser_q       <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            len_err_q   <= 1'b0;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                slot_data_q[i] <= '0;
                slot_len_q[i]  <= '0;
            end
        end else begin
            if (release_w) begin
                ser_q <= {{DBW{1'b0}}, slot_data_q[next_id_q]};
                rem_q <= slot_len_q[next_id_q];
            end else if (fire_w) begin
                ser_q <= ser_q >> DBW;
                rem_q <= rem_q - LENGTH_WIDTH'(DATA_BUS_WIDTH_BYTES);
            end

            if (fire_w && beat_last_w) begin
                next_id_q <= (next_id_q == ID_W'(NUM_ELEMENTS - 1)) ? '0 : next_id_q + 1'b1;
                count_q   <= count_q + 16'd1;
            end

            // Release empties the slot; a same-cycle capture refills it
            // (later assignment wins), so release never races a capture.
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                if (rel_slot_w[i]) begin
                    slot_full_q[i] <= 1'b0;
                end
                if (USEStreamReadyIn[i]) begin
                    if (cap_bad_w[i]) begin
                        len_err_q <= 1'b1;
                    end else if (slot_full_q[i] && !rel_slot_w[i]) begin
                        ovf_q <= 1'b1;
                    end else begin
                        slot_full_q[i] <= 1'b1;
                        slot_data_q[i] <= cap_data_w[i];
                        slot_len_q[i]  <= cap_len_w[i];
                    end
                end
            end
        end
    end

    assign overflow_error = ovf_q;
    assign length_error   = len_err_q;
    assign element_count  = count_q;

endmodule

// File: tb/tb_use_stream_collector.sv
module tb_use_stream_collector;

    localparam int NE = 6;
    localparam int BW = 8;
    localparam int MB = 38;
    localparam int LW = 6;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NE*MB*8-1:0]    USEStreamIn = '0;
    logic [NE*LW-1:0]      USEStreamByteLengthIn = '0;
    logic [NE-1:0]         USEStreamReadyIn = '0;
    logic [BW*8-1:0]       m_axis_tdata;
    logic [BW-1:0]         m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready = 1'b1;
    logic                  m_axis_tlast;
    logic                  overflow_error;
    logic                  length_error;
    logic [15:0]           element_count;

    use_stream_collector #(
        .NUM_ELEMENTS(NE), .DATA_BUS_WIDTH_BYTES(BW),
        .MAX_USE_BYTES(MB), .LENGTH_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(reset),
        .USEStreamIn(USEStreamIn),
        .USEStreamByteLengthIn(USEStreamByteLengthIn),
        .USEStreamReadyIn(USEStreamReadyIn),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .overflow_error(overflow_error), .length_error(length_error),
        .element_count(element_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t      expq[$];
    int         log_beats[$];
    logic [7:0] log_keep[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         mon_beats = 0;
    logic       prev_last_hs = 1'b0;

    function automatic logic [7:0] byte_of(int tag, int j);
        if (tag == 0) return (j == 0) ? 8'h00 : 8'(32'hA0 + j);
        return 8'(tag * 16 + j);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Fill all MB bytes so bytes past the length are non-zero and must be masked.
    task automatic load_slot(int id, int tag, int len);
        for (int j = 0; j < MB; j++) USEStreamIn[(id*MB+j)*8 +: 8] = byte_of(tag, j);
        USEStreamByteLengthIn[id*LW +: LW] = LW'(len);
    endtask

    task automatic expect_elem(int tag, int len);
        int nb;
        beat_t e;
        nb = (len + BW - 1) / BW;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            e.keep = '0;
            for (int k = 0; k < BW; k++) begin
                if (b*BW + k < len) begin
                    e.data[k*8 +: 8] = byte_of(tag, b*BW + k);
                    e.keep[k] = 1'b1;
                end
            end
            e.last = (b == nb - 1);
            expq.push_back(e);
        end
    endtask

    task automatic pulse(logic [NE-1:0] mask);
        USEStreamReadyIn = mask;
        tick(1);
        USEStreamReadyIn = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        USEStreamReadyIn = '0;
        m_axis_tready = 1'b1;
        tick(2);
        expq.delete();
        log_beats.delete();
        log_keep.delete();
        reset = 1'b0;
    endtask

    task automatic wait_count(int target, int budget);
        int n = 0;
        while (element_count != 16'(target) && n < budget) begin
            tick(1);
            n++;
        end
        check("element_count", 64'(element_count), 64'(target));
        check("queue_drained", 64'(expq.size()), 64'd0);
    endtask

    task automatic check_log(int idx, int beats, logic [7:0] keep);
        if (idx >= log_beats.size()) begin
            vectors++;
            miscompares++;
            $display("FAIL elem_log[%0d]: got no element, expected %0d beats", idx, beats);
        end else begin
            check($sformatf("beats[%0d]", idx), 64'(log_beats[idx]), 64'(beats));
            check($sformatf("last_tkeep[%0d]", idx), 64'(log_keep[idx]), 64'(keep));
        end
    endtask

    // Monitor: every presented beat is compared against the queue head, so a
    // stalled beat is re-checked each cycle; pop only on handshake.
    always @(negedge clk) begin
        if (reset) begin
            mon_beats = 0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_last_hs) check("idle_gap_tvalid", 64'(m_axis_tvalid), 64'd0);
            prev_last_hs = 1'b0;
            if (m_axis_tvalid) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got data %h keep %h, expected no beat",
                             m_axis_tdata, m_axis_tkeep);
                end else begin
                    check("tdata", m_axis_tdata, expq[0].data);
                    check("tkeep", 64'(m_axis_tkeep), 64'(expq[0].keep));
                    check("tlast", 64'(m_axis_tlast), 64'(expq[0].last));
                    if (m_axis_tready) begin
                        void'(expq.pop_front());
                        mon_beats++;
                        if (m_axis_tlast) begin
                            log_beats.push_back(mon_beats);
                            log_keep.push_back(m_axis_tkeep);
                            mon_beats = 0;
                            prev_last_hs = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    int lens  [NE] = '{21, 21, 24, 31, 19, 26};
    int nbs   [NE] = '{3, 3, 3, 4, 3, 4};
    logic [7:0] lks [NE] = '{8'h1F, 8'h1F, 8'hFF, 8'h7F, 8'h07, 8'h03};

    initial begin
        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_overflow", 64'(overflow_error), 64'd0);
        check("rst_length_err", 64'(length_error), 64'd0);
        check("rst_count", 64'(element_count), 64'd0);
        reset = 1'b0;
        tick(1);

        // Single element 0, len 27: tvalid two cycles after the pulse
        load_slot(0, 0, 27);
        expect_elem(0, 27);
        pulse(6'h01);
        check("tvalid_n+1", 64'(m_axis_tvalid), 64'd0);
        tick(1);
        check("tvalid_n+2", 64'(m_axis_tvalid), 64'd1);
        wait_count(1, 100);
        check_log(0, 4, 8'h07);

        // All six elements pulsed together
        apply_reset();
        for (int i = 0; i < NE; i++) begin
            load_slot(i, i + 1, lens[i]);
            expect_elem(i + 1, lens[i]);
        end
        pulse(6'h3F);
        wait_count(6, 400);
        for (int i = 0; i < NE; i++) check_log(i, nbs[i], lks[i]);

        // Max-length element with tready toggling every cycle
        apply_reset();
        load_slot(0, 7, 38);
        expect_elem(7, 38);
        pulse(6'h01);
        for (int n = 0; n < 300 && element_count != 16'd1; n++) begin
            m_axis_tready = ~m_axis_tready;
            tick(1);
        end
        m_axis_tready = 1'b1;
        wait_count(1, 10);
        check_log(0, 5, 8'h3F);

        // Overflow on slot 2 while next_id 0 is empty
        apply_reset();
        expect_elem(20, 10);
        expect_elem(21, 5);
        expect_elem(22, 12);
        load_slot(2, 22, 12);
        pulse(6'h04);
        load_slot(2, 23, 16);
        pulse(6'h04);
        check("overflow_set", 64'(overflow_error), 64'd1);
        check("no_length_err", 64'(length_error), 64'd0);
        tick(3);
        check("blocked_tvalid", 64'(m_axis_tvalid), 64'd0);
        load_slot(0, 20, 10);
        load_slot(1, 21, 5);
        pulse(6'h03);
        wait_count(3, 200);
        tick(10);
        check("no_extra_elem", 64'(element_count), 64'd3);
        check_log(2, 2, 8'h0F);

        // Length errors on slot 1 stall the pointer at 1
        apply_reset();
        load_slot(0, 11, 4);
        expect_elem(11, 4);
        pulse(6'h01);
        wait_count(1, 100);
        load_slot(1, 12, 0);
        pulse(6'h02);
        check("length_err_len0", 64'(length_error), 64'd1);
        load_slot(1, 12, 39);
        pulse(6'h02);
        load_slot(2, 13, 8);
        pulse(6'h04);
        tick(20);
        check("stalled_count", 64'(element_count), 64'd1);
        check("stalled_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("len_no_overflow", 64'(overflow_error), 64'd0);
        load_slot(1, 14, 9);
        expect_elem(14, 9);
        expect_elem(13, 8);
        pulse(6'h02);
        wait_count(3, 100);
        check("length_err_sticky", 64'(length_error), 64'd1);
        check_log(1, 2, 8'h01);
        check_log(2, 1, 8'hFF);

        // Reset during beat 2 of a 4-beat element
        apply_reset();
        load_slot(0, 9, 27);
        expect_elem(9, 27);
        pulse(6'h01);
        tick(2);
        check("midrst_beat2_valid", 64'(m_axis_tvalid), 64'd1);
        reset = 1'b1;
        tick(1);
        check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_count", 64'(element_count), 64'd0);
        check("midrst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("midrst_overflow", 64'(overflow_error), 64'd0);
        expq.delete();
        log_beats.delete();
        log_keep.delete();
        reset = 1'b0;
        tick(1);
        load_slot(0, 10, 13);
        expect_elem(10, 13);
        pulse(6'h01);
        wait_count(1, 100);
        check_log(0, 2, 8'h1F);

        // Capture into slot 0 in the same cycle it is released
        apply_reset();
        expect_elem(30, 8);
        for (int i = 1; i < NE; i++) expect_elem(30 + i, 8);
        expect_elem(36, 8);
        load_slot(0, 30, 8);
        pulse(6'h01);
        load_slot(0, 36, 8);
        pulse(6'h01);
        check("same_cycle_no_overflow", 64'(overflow_error), 64'd0);
        for (int i = 1; i < NE; i++) load_slot(i, 30 + i, 8);
        pulse(6'h3E);
        wait_count(7, 300);
        check("wrap_no_overflow", 64'(overflow_error), 64'd0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
